// File: rtl/coo_pkg.sv
// Shared types and default sizing for the dense-to-COO encoder.
// It holds the state enum, the default triplet layout and the index-width helper.
package coo_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 32;

  // Width needed to index n items; never drops to zero so 1x1 matrices still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(N_DEF);

  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [W_DEF-1:0] val;
  } triplet_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HDR  = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/coo_triplet_buf.sv
// Triplet store for one matrix. It has a synchronous write port and a combinational read port.
// Row and column are kept at index width, and the value at full width.
module coo_triplet_buf
  import coo_pkg::*;
#(
  parameter int DEPTH = N_DEF * N_DEF,
  parameter int IW    = IDX_W,
  parameter int W     = W_DEF,
  parameter int AW    = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wrow,
  input  logic [IW-1:0] wcol,
  input  logic [W-1:0]  wval,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rrow,
  output logic [IW-1:0] rcol,
  output logic [W-1:0]  rval
);

  logic [IW-1:0] row_mem [DEPTH];
  logic [IW-1:0] col_mem [DEPTH];
  logic [W-1:0]  val_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      row_mem[waddr] <= wrow;
      col_mem[waddr] <= wcol;
      val_mem[waddr] <= wval;
    end
  end

  assign rrow = row_mem[raddr];
  assign rcol = col_mem[raddr];
  assign rval = val_mem[raddr];

endmodule

// File: rtl/coo_encoder.sv
// Takes one dense N x N matrix, streamed in row-major order, and emits it in COO form.
// The output is a header beat {N, N, nnz} followed by nnz {row, col, val} triplets.
module coo_encoder
  import coo_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_hdr,
  output logic [W-1:0] out_row,
  output logic [W-1:0] out_col,
  output logic [W-1:0] out_val,
  output logic         out_last
);

  localparam int IW    = idx_w(N);
  localparam int DEPTH = N * N;
  localparam int AW    = idx_w(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  state_t        state_reg, state_next;
  logic [IW-1:0] row_reg, row_next;
  logic [IW-1:0] col_reg, col_next;
  logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          live_reg;

  logic          buf_we;
  logic [IW-1:0] rd_row;
  logic [IW-1:0] rd_col;
  logic [W-1:0]  rd_val;
  logic          emit_last;

  coo_triplet_buf #(
    .DEPTH(DEPTH),
    .IW   (IW),
    .W    (W),
    .AW   (AW)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(wr_ptr_reg[AW-1:0]),
    .wrow (row_reg),
    .wcol (col_reg),
    .wval (in_data),
    .raddr(rd_ptr_reg[AW-1:0]),
    .rrow (rd_row),
    .rcol (rd_col),
    .rval (rd_val)
  );

  // wr_ptr doubles as the nnz count once the matrix has been fully loaded.
  assign emit_last = (rd_ptr_reg == (wr_ptr_reg - CW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= LOAD;
      row_reg    <= '0;
      col_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      live_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      col_reg    <= col_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      live_reg   <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    col_next    = col_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    buf_we      = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_hdr     = 1'b0;
    out_last    = 1'b0;
    out_row     = '0;
    out_col     = '0;
    out_val     = '0;

    case (state_reg)
      LOAD: begin
        // live_reg keeps the input closed until the first edge after reset is released.
        in_ready = live_reg;
        if (in_valid && live_reg) begin
          buf_we = (in_data != '0);
          if (buf_we) begin
            wr_ptr_next = wr_ptr_reg + CW'(1);
          end
          if (col_reg == IW'(N - 1)) begin
            col_next = '0;
            if (row_reg == IW'(N - 1)) begin
              row_next   = '0;
              state_next = HDR;
            end else begin
              row_next = row_reg + IW'(1);
            end
          end else begin
            col_next = col_reg + IW'(1);
          end
        end
      end

      HDR: begin
        out_valid = 1'b1;
        out_hdr   = 1'b1;
        out_row   = W'(N);
        out_col   = W'(N);
        out_val   = W'(wr_ptr_reg);
        out_last  = (wr_ptr_reg == '0);
        if (out_ready) begin
          rd_ptr_next = '0;
          state_next  = (wr_ptr_reg == '0) ? LOAD : EMIT;
        end
      end

      EMIT: begin
        out_valid = 1'b1;
        out_row   = W'(rd_row);
        out_col   = W'(rd_col);
        out_val   = rd_val;
        out_last  = emit_last;
        if (out_ready) begin
          if (emit_last) begin
            state_next  = LOAD;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
          end else begin
            rd_ptr_next = rd_ptr_reg + CW'(1);
          end
        end
      end

      default: begin
        state_next = LOAD;
      end
    endcase
  end

endmodule

// File: doc/coo_encoder.md
COO_ENCODER -- requirements
Module: coo_encoder

Interface
REQ-001 Parameter N, default 4: dense matrix dimension (N x N, square).
REQ-002 Parameter W, default 32: width of element values and of every output field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  dense element present on in_data.
REQ-006 in_ready  output  1  encoder accepts an element this cycle.
REQ-007 in_data  input  W  dense element, row-major order.
REQ-008 out_valid  output  1  output beat present.
REQ-009 out_ready  input  1  downstream accepts the beat this cycle.
REQ-010 out_hdr  output  1  beat is the header {rows, cols, nnz}.
REQ-011 out_row  output  W  row index (header: N).
REQ-012 out_col  output  W  column index (header: N).
REQ-013 out_val  output  W  element value (header: nnz).
REQ-014 out_last  output  1  final beat of the matrix.

Function
REQ-015 Encoder SHALL convert one streamed dense N x N matrix into the COO stream consumed by the downstream COO multiplier: header {N,N,nnz}, then nnz triplets {row,col,val}.
REQ-016 FSM SHALL have states LOAD, HDR, EMIT; it enters LOAD on reset.
REQ-017 LOAD: in_ready=1, out_valid=0; each handshake (in_valid&in_ready) consumes element k, 0 <= k < N*N, with row=k/N, col=k%N.
REQ-018 LOAD: an element with in_data != 0 SHALL be written to the triplet buffer at wr_ptr, then wr_ptr increments; zero elements are dropped; cycles with in_valid=0 change no state.
REQ-019 Handshake on k=N*N-1 SHALL move FSM to HDR on the next edge (header valid one cycle after last input accepted).
REQ-020 HDR: out_valid=1, out_hdr=1, out_row=N, out_col=N, out_val=nnz zero-extended to W; out_last=1 only if nnz=0.
REQ-021 HDR handshake: nnz>0 -> EMIT with rd_ptr=0; nnz=0 -> LOAD with counters cleared.
REQ-022 EMIT: out_valid=1, out_hdr=0, fields from buffer[rd_ptr], zero-extended to W; out_last=1 when rd_ptr=nnz-1.
REQ-023 EMIT handshake increments rd_ptr; handshake on the last beat returns to LOAD with k, wr_ptr, rd_ptr cleared.
REQ-024 in_ready SHALL be 0 in HDR and EMIT; no input is accepted while output is pending.
REQ-025 While out_valid=1 and out_ready=0 all out_* SHALL hold stable.
REQ-026 Triplets SHALL be emitted in row-major order, identical to input order; throughput one beat per cycle when out_ready=1.
REQ-027 nnz counter width SHALL be $clog2(N*N+1) so nnz=N*N does not wrap.

Reset
REQ-028 rst=1 SHALL immediately force state=LOAD, k=0, wr_ptr=0, rd_ptr=0, nnz=0, out_valid=0, out_hdr=0, out_last=0, out_row/out_col/out_val=0, in_ready=0 while rst is asserted.
REQ-029 Reset mid-LOAD, HDR or EMIT SHALL discard the partial matrix; buffer contents need not be cleared.
REQ-030 in_ready SHALL be 1 from the first clock edge after rst deasserts.

Structure
REQ-031 Shared package coo_pkg SHALL hold N, W defaults, index width $clog2(N), the triplet struct {row,col,val} and the state enum.
REQ-032 One sub-module coo_triplet_buf SHALL implement the N*N-entry buffer (one synchronous write port, one combinational read port).
REQ-033 Buffer SHALL store row/col at index width, not W.

Verification
REQ-034 Stream rows [4,0,0,2],[0,0,1,0],[0,2,0,0],[9,0,2,0], out_ready=1 -> header (4,4,6) then (0,0,4),(0,3,2),(1,2,1),(2,1,2),(3,0,9),(3,2,2), out_last on (3,2,2).
REQ-035 Stream rows [2,0,8,2],[0,0,1,0],[3,0,4,0],[0,1,2,0], out_ready toggled 1/0 each cycle -> header (4,4,8), 8 triplets in order, outputs stable across every stall.
REQ-036 All-zero matrix -> single header beat (4,4,0) with out_last=1, then in_ready=1.
REQ-037 All-ones matrix with random in_valid gaps -> header (4,4,16), 16 triplets (r,c,1) row-major, no wrap of nnz.
REQ-038 Assert rst during EMIT after 3 triplets -> out_valid=0 at once; next matrix encodes correctly from header.
